uart_tx_ctrl: RTL

UART transmit controller. Accepts a data byte over a valid/ready handshake and loads it into a frame shift register. Sequences the frame serially (start, data LSB-first, stop) at a fixed clocks-per-bit rate. Sits between the host-side byte interface and the TX pin, and sequences the frame register datapath with load and shift enables.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame layout: start bit, DATA_BITS data bits LSB-first, stop bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned num_bits(input int unsigned data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// tick is high on the terminal count, which is the last cycle of a serial bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Wraps to zero on the terminal count, so it never exceeds LAST.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte intake, frame shift register,
// and start/data/stop sequencing at CLKS_PER_BIT clocks per bit.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned NUM_BIT = num_bits(DATA_BITS);
  localparam int unsigned BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  tx_state_t          state;
  tx_state_t          state_next;
  logic [NUM_BIT-1:0] frame;
  logic [BIT_W-1:0]   bit_cnt;
  logic               load;
  logic               shift;
  logic               baud_tick;
  logic               last_bit;
  logic               done_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (RST),
    .clr  (load),
    .en   (busy),
    .tick (baud_tick)
  );

  // The baud counter only runs while busy, so its tick already implies a frame in flight.
  assign shift    = baud_tick;
  assign last_bit = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (tx_valid)              state_next = START;
      START: if (baud_tick)             state_next = DATA;
      DATA:  if (baud_tick && last_bit) state_next = STOP;
      STOP:  if (baud_tick)             state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    load     = tx_ready && tx_valid;
  end

  // tx is the frame register LSB; idle frame is all ones so the line rests high.
  always_ff @(posedge clk) begin
    if (RST) begin
      frame   <= '1;
      bit_cnt <= '0;
    end else if (load) begin
      frame   <= {STOP_BIT, tx_data, START_BIT};
      bit_cnt <= '0;
    end else if (shift) begin
      frame <= {STOP_BIT, frame[NUM_BIT-1:1]};
      if (state == DATA) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state == STOP) && baud_tick;
    end
  end

  assign tx      = frame[0];
  assign tx_done = done_q;

endmodule
